// File: rtl/iterative_divider_32.sv
// rtl/iterative_divider_32.sv - multi-cycle restoring divider (quotient to LO, remainder to HI); optional signed mode via SIGNED_DIV_EN
module iterative_divider_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] step_quo, step_rem;
    logic [WIDTH-1:0] fin_quo, fin_rem;

`ifdef SIGNED_DIV_EN
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;
`else
    logic unused_is_signed;
    assign unused_is_signed = is_signed;
`endif

    // Datapath: one trial subtraction per cycle on the WIDTH+1-bit partial remainder.
    always_comb begin
        op_a = dividend;
        op_b = divisor;
`ifdef SIGNED_DIV_EN
        if (is_signed && dividend[WIDTH-1]) op_a = -dividend;
        if (is_signed && divisor[WIDTH-1])  op_b = -divisor;
`endif
        shifted  = {rem_q, dvd_q[WIDTH-1]};
        trial    = shifted - {1'b0, dsr_q};
        step_quo = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
        step_rem = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        fin_quo  = step_quo;
        fin_rem  = step_rem;
`ifdef SIGNED_DIV_EN
        if (neg_quo_q) fin_quo = -step_quo;
        if (neg_rem_q) fin_rem = -step_rem;
`endif
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
`ifdef SIGNED_DIV_EN
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            IDLE, FINISH: begin
                state_d = IDLE;
                if (start) begin
                    if (divisor == '0) begin
                        state_d = FINISH;
                        quo_d   = '1;
                        rmd_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        dvd_d   = op_a;
                        dsr_d   = op_b;
                        rem_d   = '0;
                        cnt_d   = CW'(WIDTH);
                        dbz_d   = 1'b0;
`ifdef SIGNED_DIV_EN
                        neg_quo_d = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_rem_d = is_signed && dividend[WIDTH-1];
`endif
                    end
                end
            end
            RUN: begin
                rem_d = step_rem;
                dvd_d = step_quo;
                cnt_d = cnt_q - CW'(1);
                // Results land on the last RUN edge so they are valid while done is high.
                if (cnt_q == CW'(1)) begin
                    state_d = FINISH;
                    quo_d   = fin_quo;
                    rmd_d   = fin_rem;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

`ifdef SIGNED_DIV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end
`endif

    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == RUN);
    assign done        = (state_q == FINISH);

endmodule

// File: tb/tb_iterative_divider_32.sv
// tb/tb_iterative_divider_32.sv - directed self-checking bench for iterative_divider_32
module tb_iterative_divider_32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        is_signed = 1'b0;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;
    int lat;
    int done_seen;

    iterative_divider_32 #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .is_signed   (is_signed),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive start for one cycle; returns in cycle k+1 (k = accepting edge).
    task automatic pulse_start(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        start     = 1'b1;
        dividend  = a;
        divisor   = b;
        is_signed = s;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts cycles from k+1 until done is seen (bounded).
    task automatic wait_done(output int cycles);
        cycles = 1;
        while (!done && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [31:0] eq, input logic [31:0] er,
                           input logic ez, input int elat);
        pulse_start(a, b, s);
        check({tag, "_busy_k1"}, {31'd0, busy}, {31'd0, (elat != 1)});
        wait_done(lat);
        check({tag, "_latency"}, lat, elat);
        check({tag, "_quotient"}, quotient, eq);
        check({tag, "_remainder"}, remainder, er);
        check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_quotient", quotient, 32'd0);
        check("reset_remainder", remainder, 32'd0);
        check("reset_flags", {29'd0, busy, done, div_by_zero}, 32'd0);
        rst_n = 1'b1;

        run_div("unsigned7", 32'h5AD76D6B, 32'h00000007, 1'b0, 32'h0CFA3433, 32'h00000006, 1'b0, 33);
        run_div("max_by_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001, 32'h00000000, 1'b0, 33);
        run_div("small", 32'h00000005, 32'h00000009, 1'b0, 32'h00000000, 32'h00000005, 1'b0, 33);

        // Results hold after done
        repeat (3) @(negedge clk);
        check("hold_quotient", quotient, 32'h00000000);
        check("hold_remainder", remainder, 32'h00000005);

        run_div("dbz", 32'h12345678, 32'h00000000, 1'b0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1);
        @(negedge clk);
        check("dbz_hold", {31'd0, div_by_zero}, 32'd1);
        run_div("dbz_clear", 32'd100, 32'd10, 1'b0, 32'd10, 32'd0, 1'b0, 33);

        // Start while busy is ignored
        pulse_start(32'd1000, 32'd3, 1'b0);
        repeat (3) @(negedge clk);
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
        @(negedge clk);
        start = 1'b0;
        lat = 5;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("ignore_latency", lat, 33);
        check("ignore_quotient", quotient, 32'd333);
        check("ignore_remainder", remainder, 32'd1);

        // Back-to-back start in the FINISH cycle
        pulse_start(32'd100, 32'd7, 1'b0);
        wait_done(lat);
        check("b2b_first_latency", lat, 33);
        check("b2b_first_quotient", quotient, 32'd14);
        check("b2b_first_remainder", remainder, 32'd2);
        start = 1'b1; dividend = 32'hFFFFFFFF; divisor = 32'h00000010;
        @(negedge clk);
        start = 1'b0;
        check("b2b_no_gap_busy", {31'd0, busy}, 32'd1);
        wait_done(lat);
        check("b2b_second_latency", lat, 33);
        check("b2b_second_quotient", quotient, 32'h0FFFFFFF);
        check("b2b_second_remainder", remainder, 32'h0000000F);

        // Reset mid-run aborts the divide
        pulse_start(32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        check("midrun_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_quotient", quotient, 32'd0);
        check("abort_remainder", remainder, 32'd0);
        check("abort_flags", {29'd0, busy, done, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        run_div("after_abort", 32'h5AD76D6B, 32'h00000007, 1'b0, 32'h0CFA3433, 32'h00000006, 1'b0, 33);

`ifdef SIGNED_DIV_EN
        run_div("signed_m7_2", 32'hFFFFFFF9, 32'h00000002, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33);
        run_div("signed_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h00000000, 1'b0, 33);
        run_div("signed_dbz", 32'hFFFFFFF9, 32'h00000000, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1);
        run_div("unsigned_flag_off", 32'hFFFFFFF9, 32'h00000002, 1'b0, 32'h7FFFFFFC, 32'h00000001, 1'b0, 33);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
